// File: rtl/line_centroid_detector_if.sv
// line_centroid_detector_if: pixel stream handshake between the frame memory and the centroid detector.
interface line_centroid_detector_if;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/line_centroid_detector.sv
// line_centroid_detector: thresholds a rotated 32x32 frame, averages dark-pixel columns in a row band
// with a restoring divider, and emits a one-hot steering decision.
module line_centroid_detector #(
    parameter int ROW_LO   = 24,
    parameter int ROW_HI   = 31,
    parameter int CENTER   = 15,
    parameter int DEADBAND = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            frame_start,
    line_centroid_detector_if.slave         pix,
    input  logic [7:0]                      threshold,
    output logic                            result_valid,
    output logic [4:0]                      centroid,
    output logic [10:0]                     dark_count,
    output logic                            steer_left,
    output logic                            steer_straight,
    output logic                            steer_right,
    output logic                            line_lost
);
    typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;
    localparam logic [4:0] LEFT_LIM  = 5'(CENTER - DEADBAND);
    localparam logic [4:0] RIGHT_LIM = 5'(CENTER + DEADBAND);
    state_t      state;
    logic [4:0]  col, row;
    logic [14:0] sum, sum_n, quo;
    logic [10:0] cnt, cnt_n, trial;
    logic [9:0]  rem;
    logic [3:0]  it;
    logic [5:0]  row6;
    logic        accept, hit, last, ge;
    always_comb begin
        row6   = {1'b0, row};
        accept = state == ACCUM && pix.pix_valid;
        hit    = accept && pix.pix_data < threshold && row6 >= 6'(ROW_LO) && row6 <= 6'(ROW_HI);
        sum_n  = sum + (hit ? 15'(col) : 15'd0);
        cnt_n  = cnt + 11'(hit);
        last   = accept && row == 5'd31 && col == 5'd31;
        trial  = {rem, sum[14]};
        ge     = trial >= cnt;
        quo    = {sum[13:0], ge};
    end
    // sum doubles as the dividend shift register; quotient bits fill in from the bottom
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ACCUM;
            {col, row, sum, cnt, rem, it} <= '0;
            pix.pix_ready  <= 1'b1;
            result_valid   <= 1'b0;
            centroid       <= '0;
            dark_count     <= '0;
            {steer_left, steer_straight, steer_right, line_lost} <= 4'b0001;
        end else if (frame_start) begin
            state         <= ACCUM;
            {col, row, sum, cnt, rem, it} <= '0;
            pix.pix_ready <= 1'b1;
            result_valid  <= 1'b0;
        end else begin
            case (state)
                ACCUM: if (accept) begin
                    col <= col + 5'd1;
                    row <= col == 5'd31 ? row + 5'd1 : row;
                    sum <= sum_n;
                    cnt <= cnt_n;
                    if (last) begin
                        pix.pix_ready <= 1'b0;
                        rem           <= '0;
                        it            <= '0;
                        if (cnt_n != 11'd0) state <= DIVIDE;
                        else begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                            centroid     <= '0;
                            dark_count   <= '0;
                            {steer_left, steer_straight, steer_right, line_lost} <= 4'b0001;
                        end
                    end
                end
                DIVIDE: begin
                    rem <= ge ? 10'(trial - cnt) : trial[9:0];
                    sum <= quo;
                    it  <= it + 4'd1;
                    if (it == 4'd14) begin
                        state          <= DONE;
                        result_valid   <= 1'b1;
                        centroid       <= quo[4:0];
                        dark_count     <= cnt;
                        steer_left     <= quo[4:0] < LEFT_LIM;
                        steer_right    <= quo[4:0] > RIGHT_LIM;
                        steer_straight <= quo[4:0] >= LEFT_LIM && quo[4:0] <= RIGHT_LIM;
                        line_lost      <= 1'b0;
                    end
                end
                default: begin
                    state         <= ACCUM;
                    result_valid  <= 1'b0;
                    pix.pix_ready <= 1'b1;
                    {col, row, sum, cnt} <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_centroid_detector.sv
// tb_line_centroid_detector: directed frames with hand-computed centroids, latencies and decisions.
module tb_line_centroid_detector;
    logic clk = 0, reset = 1, frame_start = 0;
    logic [7:0] threshold = 8'd128;
    logic result_valid, steer_left, steer_straight, steer_right, line_lost;
    logic [4:0] centroid;
    logic [10:0] dark_count;
    int checks = 0, errors = 0;
    int n, rlow;
    line_centroid_detector_if pif ();
    line_centroid_detector dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pix(pif.slave), .threshold(threshold),
        .result_valid(result_valid), .centroid(centroid), .dark_count(dark_count),
        .steer_left(steer_left), .steer_straight(steer_straight), .steer_right(steer_right),
        .line_lost(line_lost)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    function automatic logic [7:0] pixel(input int mode, input int r, input int c);
        bit d;
        case (mode)
            0: d = c == 10 || c == 11;
            1: d = (c == 15 || c == 16) && r >= 24;
            2: d = c == 30 || (c == 0 && r < 24);
            default: d = 0;
        endcase
        return d ? 8'd20 : 8'd200;
    endfunction
    // leaves the bench at the negedge of the first cycle after the last accepted pixel
    task automatic send(input int mode, input bit gap, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (gap) begin
                pif.pix_valid = 0;
                @(negedge clk);
            end
            pif.pix_valid = 1;
            pif.pix_data  = pixel(mode, i / 32, i % 32);
            @(negedge clk);
        end
        pif.pix_valid = 0;
    endtask
    task automatic wait_result(output int cyc, output int low);
        cyc = 1;
        low = 0;
        while (!result_valid && cyc < 40) begin
            if (!pif.pix_ready) low++;
            @(negedge clk);
            cyc++;
        end
        if (!pif.pix_ready) low++;
    endtask
    task automatic chk_result(input string tag, input int lat, input int c, input int d, input int st);
        wait_result(n, rlow);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_ready_low"}, rlow, lat);
        chk({tag, "_centroid"}, centroid, c);
        chk({tag, "_dark_count"}, dark_count, d);
        chk({tag, "_steer"}, {steer_left, steer_straight, steer_right, line_lost}, st);
        @(negedge clk);
        chk({tag, "_pulse_once"}, result_valid, 0);
        chk({tag, "_ready_back"}, pif.pix_ready, 1);
    endtask
    task automatic chk_reset_state(input string tag);
        chk({tag, "_rv"}, result_valid, 0);
        chk({tag, "_ready"}, pif.pix_ready, 1);
        chk({tag, "_centroid"}, centroid, 0);
        chk({tag, "_dark_count"}, dark_count, 0);
        chk({tag, "_steer"}, {steer_left, steer_straight, steer_right, line_lost}, 1);
    endtask
    initial begin
        int seen;
        pif.pix_valid = 0;
        pif.pix_data  = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        chk_reset_state("reset");
        send(0, 0, 1024);
        chk_result("left", 16, 10, 16, 8);
        send(1, 0, 1024);
        chk_result("straight", 16, 15, 16, 4);
        send(2, 0, 1024);
        chk_result("right", 16, 30, 8, 2);
        send(1, 0, 1024);
        repeat (4) @(negedge clk);
        frame_start = 1;
        @(negedge clk);
        frame_start = 0;
        chk("abort_ready", pif.pix_ready, 1);
        chk("abort_rv", result_valid, 0);
        chk("abort_held_centroid", centroid, 30);
        chk("abort_held_dark", dark_count, 8);
        chk("abort_held_steer", {steer_left, steer_straight, steer_right, line_lost}, 2);
        seen = 0;
        repeat (20) begin
            if (result_valid) seen++;
            @(negedge clk);
        end
        chk("abort_no_result", seen, 0);
        frame_start = 1;
        pif.pix_valid = 1;
        pif.pix_data = 8'd20;
        @(negedge clk);
        frame_start = 0;
        send(3, 0, 1024);
        chk_result("lost", 1, 0, 0, 1);
        send(0, 1, 1024);
        chk_result("gapped", 16, 10, 16, 8);
        send(0, 0, 300);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk_reset_state("mid_reset");
        send(1, 0, 1024);
        chk_result("after_reset", 16, 15, 16, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
